div_unit: RTL and testbench

- Iterative radix-2 restoring divider for MIPS DIV/DIVU in the execute stage; produces the 64-bit {HI, LO} result written via the hilo path.
- Drives stall_o, which the hazard unit ORs into its stall/flush logic while a divide is outstanding.
- The result travels with the instruction through M/W like any other hilo write.

---
 rtl/cpu_defs.sv | 23 ++
 rtl/div_unit_step.sv | 33 +++
 rtl/div_unit.sv | 119 +++++++++++
 tb/tb_div_unit.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_defs.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cpu_defs : shared CPU constants (data width, divider states, hilo WE) |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package cpu_defs;

  localparam int DATA_W = 32;

  localparam logic [1:0] DIV_IDLE    = 2'b00;
  localparam logic [1:0] DIV_DIVZERO = 2'b01;
  localparam logic [1:0] DIV_ON      = 2'b10;
  localparam logic [1:0] DIV_END     = 2'b11;

  // Downstream stages commit result_o to HI and LO together.
  typedef logic [1:0] hiloWe_t;
  localparam hiloWe_t HILO_WE_NONE = 2'b00;
  localparam hiloWe_t HILO_WE_LO   = 2'b01;
  localparam hiloWe_t HILO_WE_HI   = 2'b10;
  localparam hiloWe_t HILO_WE_BOTH = 2'b11;

endpackage
`default_nettype wire

// File: rtl/div_unit_step.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | div_step : one combinational radix-2 restoring division iteration    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module div_step #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] i_rem,
  input  logic [DATA_W-1:0] i_dividend,
  input  logic [DATA_W-1:0] i_divisor,
  output logic [DATA_W-1:0] o_rem,
  output logic [DATA_W-1:0] o_dividend
);

  logic [DATA_W:0] w_shifted;
  logic [DATA_W:0] w_trial;

  // The partial remainder stays below the divisor, so DATA_W+1 bits never overflow.
  always_comb begin
    w_shifted = {i_rem, i_dividend[DATA_W-1]};
    w_trial   = w_shifted - {1'b0, i_divisor};
    if (!w_trial[DATA_W]) begin
      o_rem      = w_trial[DATA_W-1:0];
      o_dividend = {i_dividend[DATA_W-2:0], 1'b1};
    end else begin
      o_rem      = w_shifted[DATA_W-1:0];
      o_dividend = {i_dividend[DATA_W-2:0], 1'b0};
    end
  end

endmodule
`default_nettype wire

// File: rtl/div_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | div_unit : iterative restoring divider for MIPS DIV/DIVU -> {HI, LO} |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module div_unit #(
  parameter int DATA_W = cpu_defs::DATA_W,
  parameter int CNT_W  = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  annul_i,
  input  logic                  signed_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o,
  output logic                  stall_o
);

  import cpu_defs::*;

  localparam logic [CNT_W-1:0] c_lastCnt = CNT_W'(DATA_W - 1);

  logic [1:0]          r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [DATA_W-1:0]   r_rem;
  logic [DATA_W-1:0]   r_dividend;
  logic [DATA_W-1:0]   r_divisor;
  logic                r_signed;
  logic                r_negDividend;
  logic                r_negDivisor;
  logic [2*DATA_W-1:0] r_result;

  logic [DATA_W-1:0]   w_absDividend;
  logic [DATA_W-1:0]   w_absDivisor;
  logic [DATA_W-1:0]   w_stepRem;
  logic [DATA_W-1:0]   w_stepDividend;
  logic [DATA_W-1:0]   w_quoFinal;
  logic [DATA_W-1:0]   w_remFinal;
  logic                w_negQuo;
  logic                w_negRem;

  assign w_absDividend = (signed_i && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
  assign w_absDivisor  = (signed_i && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;

  div_step #(
    .DATA_W (DATA_W)
  ) u_step (
    .i_rem      (r_rem),
    .i_dividend (r_dividend),
    .i_divisor  (r_divisor),
    .o_rem      (w_stepRem),
    .o_dividend (w_stepDividend)
  );

  // Truncation toward zero: remainder takes the dividend's sign.
  assign w_negQuo   = r_signed & (r_negDividend ^ r_negDivisor);
  assign w_negRem   = r_signed & r_negDividend;
  assign w_quoFinal = w_negQuo ? -w_stepDividend : w_stepDividend;
  assign w_remFinal = w_negRem ? -w_stepRem : w_stepRem;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= DIV_IDLE;
      r_cnt         <= '0;
      r_rem         <= '0;
      r_dividend    <= '0;
      r_divisor     <= '0;
      r_signed      <= 1'b0;
      r_negDividend <= 1'b0;
      r_negDivisor  <= 1'b0;
      r_result      <= '0;
    end else if (annul_i) begin
      r_state <= DIV_IDLE;
    end else begin
      case (r_state)
        DIV_IDLE: begin
          if (start_i) begin
            r_signed      <= signed_i;
            r_negDividend <= opdata1_i[DATA_W-1];
            r_negDivisor  <= opdata2_i[DATA_W-1];
            r_dividend    <= w_absDividend;
            r_divisor     <= w_absDivisor;
            r_rem         <= '0;
            r_cnt         <= '0;
            r_state       <= (w_absDivisor == '0) ? DIV_DIVZERO : DIV_ON;
          end
        end
        DIV_DIVZERO: begin
          r_result <= '0;
          r_state  <= DIV_END;
        end
        DIV_ON: begin
          r_rem      <= w_stepRem;
          r_dividend <= w_stepDividend;
          r_cnt      <= r_cnt + CNT_W'(1);
          if (r_cnt == c_lastCnt) begin
            r_result <= {w_remFinal, w_quoFinal};
            r_state  <= DIV_END;
          end
        end
        DIV_END: begin
          r_state <= DIV_IDLE;
        end
        default: begin
          r_state <= DIV_IDLE;
        end
      endcase
    end
  end

  assign result_o = r_result;
  assign ready_o  = (r_state == DIV_END);
  assign stall_o  = start_i & ~ready_o & ~annul_i;

endmodule
`default_nettype wire

// File: tb/tb_div_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_div_unit : directed + random checks of div_unit vs arithmetic model|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_div_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic        annul;
  logic        isSigned;
  logic [31:0] opA;
  logic [31:0] opB;
  logic [63:0] result;
  logic        ready;
  logic        stall;

  int testCnt = 0;
  int failCnt = 0;

  div_unit #(
    .DATA_W (32),
    .CNT_W  (6)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start_i   (start),
    .annul_i   (annul),
    .signed_i  (isSigned),
    .opdata1_i (opA),
    .opdata2_i (opB),
    .result_o  (result),
    .ready_o   (ready),
    .stall_o   (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // MIPS semantics straight from integer arithmetic: truncating division, remainder
  // follows the dividend, divide-by-zero yields 0.
  function automatic logic [63:0] refDiv(input bit s, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    logic [31:0] q, r;
    if (b == 32'd0) return 64'd0;
    if (s) begin
      sa = longint'(signed'(a));
      sb = longint'(signed'(b));
      q  = 32'(sa / sb);
      r  = 32'(sa % sb);
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    testCnt++;
    assert (obs === exp) else begin
      failCnt++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic waitReady(input int limit, output int edges, output int stallCnt);
    edges    = 0;
    stallCnt = 0;
    while (edges < limit) begin
      @(posedge clk);
      #1;
      edges++;
      if (ready) break;
      if (stall) stallCnt++;
    end
  endtask

  task automatic runOne(input string tag, input bit s, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] expRes, input int expLat);
    int edges, sc, stallCnt;
    logic [63:0] held;
    @(negedge clk);
    start = 1'b1; isSigned = s; opA = a; opB = b;
    #1;
    stallCnt = stall ? 1 : 0;
    waitReady(100, edges, sc);
    stallCnt += sc;
    check({tag, " latency"}, 64'(edges), 64'(expLat));
    check({tag, " stall cycles"}, 64'(stallCnt), 64'(expLat));
    check({tag, " result"}, result, expRes);
    check({tag, " stall at ready"}, 64'(stall), 64'd0);
    held  = result;
    start = 1'b0;
    @(posedge clk);
    #1;
    check({tag, " ready pulse width"}, 64'(ready), 64'd0);
    check({tag, " result held"}, result, held);
  endtask

  initial begin
    int edges, sc, seen;
    logic [63:0] prevRes;
    logic [31:0] a, b;
    bit s;

    rst = 1'b1; start = 1'b0; annul = 1'b0; isSigned = 1'b0; opA = '0; opB = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset result", result, 64'd0);
    check("reset ready", 64'(ready), 64'd0);
    check("reset stall", 64'(stall), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    runOne("divu 100/7", 1'b0, 32'd100, 32'd7, {32'h2, 32'hE}, 33);
    runOne("div -7/2", 1'b1, 32'hFFFF_FFF9, 32'h2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33);
    runOne("div 7/-2", 1'b1, 32'h7, 32'hFFFF_FFFE, {32'h1, 32'hFFFF_FFFD}, 33);
    runOne("div min/-1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000}, 33);
    runOne("divu max/1", 1'b0, 32'hFFFF_FFFF, 32'h1, {32'h0, 32'hFFFF_FFFF}, 33);
    runOne("divu 5/0", 1'b0, 32'd5, 32'd0, 64'd0, 2);

    // Back-to-back with start held: the next operands appear once the first result is out.
    @(negedge clk);
    start = 1'b1; isSigned = 1'b0; opA = 32'd9; opB = 32'd3;
    waitReady(100, edges, sc);
    check("b2b first latency", 64'(edges), 64'd33);
    check("b2b first result", result, {32'd0, 32'd3});
    opA = 32'd10; opB = 32'd4;
    waitReady(100, edges, sc);
    check("b2b gap", 64'(edges), 64'd34);
    check("b2b second stall cycles", 64'(sc), 64'd33);
    check("b2b second result", result, {32'd2, 32'd2});
    start = 1'b0;
    @(posedge clk);
    #1;
    check("b2b ready drop", 64'(ready), 64'd0);

    // Annul mid-divide while start stays high, then hold both high in IDLE.
    prevRes = result;
    @(negedge clk);
    start = 1'b1; isSigned = 1'b0; opA = 32'd1000; opB = 32'd3;
    repeat (11) @(posedge clk);
    @(negedge clk);
    annul = 1'b1;
    #1;
    check("annul stall", 64'(stall), 64'd0);
    @(posedge clk);
    #1;
    check("annul ready 1", 64'(ready), 64'd0);
    @(posedge clk);
    #1;
    check("annul ready 2", 64'(ready), 64'd0);
    @(negedge clk);
    annul = 1'b0; start = 1'b0;
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (ready) seen = 1;
    end
    check("annul no pulse", 64'(seen), 64'd0);
    check("annul result kept", result, prevRes);

    // Reset at iteration 20 clears everything.
    @(negedge clk);
    start = 1'b1; isSigned = 1'b1; opA = 32'hFFFF_0000; opB = 32'd77;
    repeat (21) @(posedge clk);
    @(negedge clk);
    rst = 1'b1; start = 1'b0;
    @(posedge clk);
    #1;
    check("midrst result", result, 64'd0);
    check("midrst ready", 64'(ready), 64'd0);
    check("midrst stall", 64'(stall), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (ready) seen = 1;
    end
    check("midrst no pulse", 64'(seen), 64'd0);

    for (int i = 0; i < 12; i++) begin
      s = 1'($urandom_range(0, 1));
      a = $urandom;
      case ($urandom_range(0, 5))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 15));
        2:       b = 32'hFFFF_FFFF;
        3:       begin b = $urandom; a = 32'($urandom_range(0, 255)); end
        default: b = $urandom;
      endcase
      runOne($sformatf("rand%0d", i), s, a, b, refDiv(s, a, b), (b == 32'd0) ? 2 : 33);
    end

    $display("[TB] %0d tests run, %0d failed", testCnt, failCnt);
    $finish;
  end

endmodule
`default_nettype wire
